// File: rtl/dma_pkg.sv
// Shared DMA types: line-pair generator FSM states and the read-command record.
package dma_pkg;

  // Widths of the command record; generator parameters are expected not to exceed these.
  localparam int DMA_ADDR_W = 32;
  localparam int DMA_LEN_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC_EVEN,
    ST_SEND_EVEN,
    ST_CALC_ODD,
    ST_SEND_ODD
  } lpag_state_e;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] addr;
    logic [DMA_LEN_W-1:0]  len;
    logic                  odd;
    logic                  last;
  } dma_cmd_t;

endpackage

// File: rtl/line_addr_calc.sv
// Registered line start address: base + line*stride, wrapping at 2^ADDR_W.
module line_addr_calc #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [ADDR_W-1:0] line,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] offset;

  assign offset = line * stride;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  addr <= '0;
    else if (en) addr <= base + offset;
  end

endmodule

// File: rtl/line_pair_addr_gen.sv
// Turns (even, odd) line-number pairs into two DMA read commands per pair,
// using a per-frame base/stride/length configuration sampled on new_frame_i.
module line_pair_addr_gen
  import dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              new_frame_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [LEN_W-1:0]  hsize_i,
  input  logic              pair_valid_i,
  output logic              pair_ready_o,
  input  logic [ADDR_W-1:0] even_line_num_i,
  input  logic [ADDR_W-1:0] odd_line_num_i,
  input  logic              last_line_i,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic [LEN_W-1:0]  cmd_len_o,
  output logic              cmd_odd_o,
  output logic              cmd_last_o,
  output logic              frame_done_o
);

  lpag_state_e       state, state_next;
  logic              armed;
  logic [ADDR_W-1:0] base_q, stride_q, even_q, odd_q;
  logic [LEN_W-1:0]  len_q;
  logic              last_q;
  logic              calc_en;
  logic [ADDR_W-1:0] calc_line, calc_addr;
  logic              pair_hs, cmd_hs;
  dma_cmd_t          cmd;

  line_addr_calc #(.ADDR_W(ADDR_W)) u_calc (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .en     (calc_en),
    .base   (base_q),
    .stride (stride_q),
    .line   (calc_line),
    .addr   (calc_addr)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next   = state;
    pair_ready_o = 1'b0;
    cmd_valid_o  = 1'b0;
    calc_en      = 1'b0;
    calc_line    = even_q;
    unique case (state)
      ST_IDLE: begin
        pair_ready_o = armed && !new_frame_i;
        if (pair_valid_i && pair_ready_o) state_next = ST_CALC_EVEN;
      end
      ST_CALC_EVEN: begin
        calc_en    = 1'b1;
        state_next = ST_SEND_EVEN;
      end
      ST_SEND_EVEN: begin
        cmd_valid_o = 1'b1;
        if (cmd_ready_i) state_next = ST_CALC_ODD;
      end
      ST_CALC_ODD: begin
        calc_en    = 1'b1;
        calc_line  = odd_q;
        state_next = ST_SEND_ODD;
      end
      ST_SEND_ODD: begin
        cmd_valid_o = 1'b1;
        if (cmd_ready_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // A new frame aborts whatever pair is in flight.
    if (new_frame_i) state_next = ST_IDLE;
  end

  assign pair_hs = pair_valid_i && pair_ready_o;
  assign cmd_hs  = cmd_valid_o && cmd_ready_i;

  // Command fields are zero outside SEND so idle/reset outputs read as 0.
  always_comb begin
    cmd = '0;
    if (cmd_valid_o) begin
      cmd.addr = DMA_ADDR_W'(calc_addr);
      cmd.len  = DMA_LEN_W'(len_q);
      cmd.odd  = (state == ST_SEND_ODD);
      cmd.last = (state == ST_SEND_ODD) && last_q;
    end
  end

  assign cmd_addr_o = ADDR_W'(cmd.addr);
  assign cmd_len_o  = LEN_W'(cmd.len);
  assign cmd_odd_o  = cmd.odd;
  assign cmd_last_o = cmd.last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      armed        <= 1'b0;
      base_q       <= '0;
      stride_q     <= '0;
      len_q        <= '0;
      even_q       <= '0;
      odd_q        <= '0;
      last_q       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (new_frame_i) begin
        base_q   <= base_addr_i;
        stride_q <= stride_i;
        len_q    <= hsize_i;
        armed    <= 1'b1;
      end else if (cmd_hs && cmd_last_o) begin
        armed        <= 1'b0;
        frame_done_o <= 1'b1;
      end
      if (pair_hs) begin
        even_q <= even_line_num_i;
        odd_q  <= odd_line_num_i;
        last_q <= last_line_i;
      end
    end
  end

endmodule

// File: tb/tb_line_pair_addr_gen.sv
// Directed bench for line_pair_addr_gen: addressing, latency, stalls, frame end, abort and reset.
module tb_line_pair_addr_gen;

  localparam int AW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          new_frame;
  logic [AW-1:0] base, stride;
  logic [LW-1:0] hsize;
  logic          pair_valid, pair_ready;
  logic [AW-1:0] even_line, odd_line;
  logic          last_line;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          cmd_odd, cmd_last, frame_done;

  int n_assert = 0;
  int n_fail   = 0;
  int cmd_cnt  = 0;
  int done_cnt = 0;
  int c0, d0;

  always #5 clk = ~clk;

  line_pair_addr_gen #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .new_frame_i     (new_frame),
    .base_addr_i     (base),
    .stride_i        (stride),
    .hsize_i         (hsize),
    .pair_valid_i    (pair_valid),
    .pair_ready_o    (pair_ready),
    .even_line_num_i (even_line),
    .odd_line_num_i  (odd_line),
    .last_line_i     (last_line),
    .cmd_valid_o     (cmd_valid),
    .cmd_ready_i     (cmd_ready),
    .cmd_addr_o      (cmd_addr),
    .cmd_len_o       (cmd_len),
    .cmd_odd_o       (cmd_odd),
    .cmd_last_o      (cmd_last),
    .frame_done_o    (frame_done)
  );

  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) cmd_cnt <= cmd_cnt + 1;
    if (frame_done)             done_cnt <= done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [LW-1:0] h);
    new_frame = 1'b1; base = b; stride = s; hsize = h;
    @(posedge clk); #1;
    new_frame = 1'b0; base = 32'hDEAD_BEEF; stride = 32'h1234; hsize = 16'h5555;
  endtask

  task automatic push_pair(input string tag, input logic [AW-1:0] e, input logic [AW-1:0] o, input logic l);
    bit got = 1'b0;
    pair_valid = 1'b1; even_line = e; odd_line = o; last_line = l;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (pair_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    pair_valid = 1'b0;
    check({tag, " accepted"}, 64'(got), 64'd1);
  endtask

  task automatic take_cmd(input string tag, input logic [AW-1:0] a, input logic [LW-1:0] len,
                          input logic odd, input logic last);
    bit got = 1'b0;
    cmd_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (cmd_valid) begin
        got = 1'b1;
        check({tag, " addr"}, 64'(cmd_addr), 64'(a));
        check({tag, " len"},  64'(cmd_len),  64'(len));
        check({tag, " odd"},  64'(cmd_odd),  64'(odd));
        check({tag, " last"}, 64'(cmd_last), 64'(last));
      end
      @(posedge clk); #1;
    end
    cmd_ready = 1'b0;
    check({tag, " seen"}, 64'(got), 64'd1);
  endtask

  task automatic check_refuse(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, " pair_ready"}, 64'(pair_ready), 64'd0);
      check({tag, " cmd_valid"},  64'(cmd_valid),  64'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " pair_ready"}, 64'(pair_ready), 64'd0);
    check({tag, " cmd_valid"},  64'(cmd_valid),  64'd0);
    check({tag, " cmd_addr"},   64'(cmd_addr),   64'd0);
    check({tag, " cmd_len"},    64'(cmd_len),    64'd0);
    check({tag, " cmd_odd"},    64'(cmd_odd),    64'd0);
    check({tag, " cmd_last"},   64'(cmd_last),   64'd0);
    check({tag, " frame_done"}, 64'(frame_done), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; new_frame = 1'b0; base = '0; stride = '0; hsize = '0;
    pair_valid = 1'b0; even_line = '0; odd_line = '0; last_line = 1'b0; cmd_ready = 1'b0;
    #22;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Pairs offered before any frame start are refused
    pair_valid = 1'b1; even_line = 0; odd_line = 1;
    check_refuse("no_frame", 3);
    pair_valid = 1'b0;

    // Basic pair with exact latency
    start_frame(32'h1000, 32'h200, 16'h1FF);
    push_pair("p01", 0, 1, 1'b0);
    cmd_ready = 1'b1;
    @(negedge clk); check("lat calc_even valid", 64'(cmd_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat even valid", 64'(cmd_valid), 64'd1);
    check("lat even addr",  64'(cmd_addr),  64'h1000);
    check("lat even odd",   64'(cmd_odd),   64'd0);
    check("lat even len",   64'(cmd_len),   64'h1FF);
    check("lat even last",  64'(cmd_last),  64'd0);
    @(posedge clk); #1;
    @(negedge clk); check("lat calc_odd valid", 64'(cmd_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat odd valid", 64'(cmd_valid), 64'd1);
    check("lat odd addr",  64'(cmd_addr),  64'h1200);
    check("lat odd odd",   64'(cmd_odd),   64'd1);
    check("lat odd len",   64'(cmd_len),   64'h1FF);
    check("lat odd last",  64'(cmd_last),  64'd0);
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    @(negedge clk);
    check("idle pair_ready", 64'(pair_ready), 64'd1);
    check("idle cmd_valid",  64'(cmd_valid),  64'd0);
    @(posedge clk); #1;

    // Downstream stall in SEND_EVEN
    push_pair("p23", 2, 3, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall valid",      64'(cmd_valid),  64'd1);
      check("stall addr",       64'(cmd_addr),   64'h1400);
      check("stall odd",        64'(cmd_odd),    64'd0);
      check("stall pair_ready", 64'(pair_ready), 64'd0);
      @(posedge clk); #1;
    end
    c0 = cmd_cnt;
    cmd_ready = 1'b1;
    @(negedge clk); check("stall release addr", 64'(cmd_addr), 64'h1400);
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    @(negedge clk);
    check("stall no dup valid", 64'(cmd_valid), 64'd0);
    check("stall one handshake", 64'(cmd_cnt - c0), 64'd1);
    take_cmd("stall odd", 32'h1600, 16'h1FF, 1'b1, 1'b0);

    // Full frame of 8 pairs, last flag on (14,15)
    start_frame(32'h1000, 32'h200, 16'h1FF);
    c0 = cmd_cnt; d0 = done_cnt;
    for (int k = 0; k < 8; k++) begin
      push_pair("frame pair", AW'(2*k), AW'(2*k+1), k == 7);
      take_cmd("frame even", AW'(32'h1000 + (2*k)*32'h200), 16'h1FF, 1'b0, 1'b0);
      take_cmd("frame odd", AW'(32'h1000 + (2*k+1)*32'h200), 16'h1FF, 1'b1, k == 7);
    end
    @(negedge clk); check("frame_done pulse", 64'(frame_done), 64'd1);
    @(posedge clk); #1;
    @(negedge clk); check("frame_done drop", 64'(frame_done), 64'd0);
    check("frame cmd count",  64'(cmd_cnt - c0),  64'd16);
    check("frame done count", 64'(done_cnt - d0), 64'd1);
    @(posedge clk); #1;
    pair_valid = 1'b1; even_line = 16; odd_line = 17;
    check_refuse("disarmed", 3);
    pair_valid = 1'b0;

    // Address wrap and mirrored (even==odd) pair
    start_frame(32'hFFFF_FF00, 32'h200, 16'h3F);
    push_pair("wrap pair", 1, 2, 1'b0);
    take_cmd("wrap even", 32'h0000_0100, 16'h3F, 1'b0, 1'b0);
    take_cmd("wrap odd",  32'h0000_0300, 16'h3F, 1'b1, 1'b0);
    push_pair("mirror pair", 5, 5, 1'b0);
    take_cmd("mirror even", 32'h0000_0900, 16'h3F, 1'b0, 1'b0);
    take_cmd("mirror odd",  32'h0000_0900, 16'h3F, 1'b1, 1'b0);

    // Abort with new_frame during SEND_ODD
    start_frame(32'h1000, 32'h200, 16'h1FF);
    push_pair("abort pair", 0, 1, 1'b1);
    take_cmd("abort even", 32'h1000, 16'h1FF, 1'b0, 1'b0);
    d0 = done_cnt;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort send_odd valid", 64'(cmd_valid), 64'd1);
    check("abort send_odd last",  64'(cmd_last),  64'd1);
    @(posedge clk); #1;
    start_frame(32'h8000, 32'h100, 16'h7F);
    @(negedge clk);
    check("abort valid drop", 64'(cmd_valid),  64'd0);
    check("abort no done",    64'(frame_done), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort no done later", 64'(frame_done), 64'd0);
    check("abort done count",    64'(done_cnt - d0), 64'd0);
    @(posedge clk); #1;
    push_pair("new cfg pair", 0, 1, 1'b0);
    take_cmd("new cfg even", 32'h8000, 16'h7F, 1'b0, 1'b0);
    take_cmd("new cfg odd",  32'h8100, 16'h7F, 1'b1, 1'b0);

    // Asynchronous reset while in CALC_ODD
    push_pair("rst pair", 2, 3, 1'b0);
    take_cmd("rst even", 32'h8200, 16'h7F, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("async rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pair_valid = 1'b1; even_line = 0; odd_line = 1;
    check_refuse("post rst", 3);
    start_frame(32'h1000, 32'h200, 16'h1FF);
    push_pair("post rst pair", 0, 1, 1'b0);
    take_cmd("post rst even", 32'h1000, 16'h1FF, 1'b0, 1'b0);
    take_cmd("post rst odd",  32'h1200, 16'h1FF, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/line_pair_addr_gen.md
LINE_PAIR_ADDR_GEN -- requirements
Module: line_pair_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address and line-number width.
REQ-002 SHALL have parameter LEN_W, default 16, burst length width.
REQ-003 SHALL have port clk_i  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_ni  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port new_frame_i  in  1  one-cycle frame start; samples configuration.
REQ-006 SHALL have port base_addr_i  in  ADDR_W  frame byte base address.
REQ-007 SHALL have port stride_i  in  ADDR_W  bytes between consecutive lines.
REQ-008 SHALL have port hsize_i  in  LEN_W  line length in bytes minus 1.
REQ-009 SHALL have port pair_valid_i  in  1  line-number pair available.
REQ-010 SHALL have port pair_ready_o  out  1  pair accepted when valid and ready are both high.
REQ-011 SHALL have ports even_line_num_i, odd_line_num_i  in  ADDR_W  each; line indices of the pair.
REQ-012 SHALL have port last_line_i  in  1  pair is the final pair of the frame.
REQ-013 SHALL have port cmd_valid_o  out  1  read command valid.
REQ-014 SHALL have port cmd_ready_i  in  1  downstream DMA accepts command.
REQ-015 SHALL have port cmd_addr_o  out  ADDR_W  line start byte address.
REQ-016 SHALL have port cmd_len_o  out  LEN_W  copy of sampled hsize.
REQ-017 SHALL have port cmd_odd_o  out  1  0 = even line, 1 = odd line.
REQ-018 SHALL have port cmd_last_o  out  1  final command of the frame.
REQ-019 SHALL have port frame_done_o  out  1  one-cycle pulse after the final command handshake.

Function
REQ-020 SHALL sample base_addr_i, stride_i and hsize_i on new_frame_i, set armed=1, and ignore these inputs at all other times.
REQ-021 SHALL implement FSM IDLE, CALC_EVEN, SEND_EVEN, CALC_ODD, SEND_ODD.
REQ-022 SHALL drive pair_ready_o = armed AND state==IDLE AND NOT new_frame_i.
REQ-023 SHALL register even, odd and last on pair handshake, then go IDLE->CALC_EVEN.
REQ-024 SHALL compute addr = base + line*stride modulo 2^ADDR_W in CALC states (one cycle, registered), then go to SEND.
REQ-025 SHALL assert cmd_valid_o only in SEND states, with all cmd_* outputs stable until handshake.
REQ-026 SHALL give latency: cmd_valid_o high in the 2nd cycle after pair acceptance edge, and odd command high in the 2nd cycle after even handshake edge.
REQ-027 SHALL go SEND_EVEN->CALC_ODD on handshake, and SEND_ODD->IDLE on handshake.
REQ-028 SHALL set cmd_last_o=1 only on the odd command of a pair whose last flag is set.
REQ-029 SHALL, on the cmd_last_o handshake, pulse frame_done_o in the following cycle and clear armed.
REQ-030 SHALL send both commands even when even==odd (mirrored edge lines); no deduplication.
REQ-031 SHALL, on new_frame_i in any state, abort in flight: state->IDLE, cmd_valid_o low next cycle, no frame_done_o, new config loaded.
REQ-032 SHALL keep pair_ready_o low while disarmed; pairs presented then are neither consumed nor dropped.

Reset
REQ-033 SHALL on rst_ni low asynchronously force state=IDLE, armed=0, and all outputs 0, including pair_ready_o, cmd_valid_o, cmd_addr_o, cmd_len_o, cmd_odd_o, cmd_last_o and frame_done_o.
REQ-034 SHALL require new_frame_i after reset deassertion before accepting any pair.

Structure
REQ-035 SHALL take the FSM state enum and the command record type (addr, len, odd, last) from shared package dma_pkg.
REQ-036 SHALL place address arithmetic in sub-module line_addr_calc (registered base + line*stride).

Verification
REQ-037 Bench SHALL check: base 0x1000, stride 0x200, hsize 0x1FF, pair (0,1) -> cmds 0x1000 odd=0, 0x1200 odd=1, len 0x1FF.
REQ-038 Bench SHALL check: cmd_ready_i low 5 cycles during SEND_EVEN -> cmd outputs held stable, pair_ready_o low, no duplicate cmd.
REQ-039 Bench SHALL check: 8 pairs, last on pair (14,15) -> 16 cmds, cmd_last_o only on addr base+15*stride, frame_done_o one pulse, then pair_ready_o low.
REQ-040 Bench SHALL check: base 0xFFFF_FF00, stride 0x200, line 1 -> cmd_addr_o 0x0000_0100 (wrap).
REQ-041 Bench SHALL check: new_frame_i during SEND_ODD with base 0x8000 -> cmd_valid_o drops, no frame_done_o, next pair (0,1) gives 0x8000.
REQ-042 Bench SHALL check: rst_ni low mid-CALC_ODD -> all outputs 0 immediately, pairs refused until new_frame_i.
